pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the PLL/oscillator primitive, in the PLL output clock domain.
- Consumes the PLL lock indication and synchronises it.
- Holds the system reset asserted until lock has been stable for a programmable number of cycles, then releases it.
- While running, generates a periodic one-cycle tick and a heartbeat toggle. On loss of lock it re-asserts system reset and counts the event.

Parameters:
- STABLE_CYCLES, 1024: consecutive locked cycles required before sys_rst_n is released; must be >= 2.
- TICK_DIV, 12000: clk cycles per tick; must be >= 2.
- HB_TICKS, 500: ticks per heartbeat toggle; must be >= 1.
- LOSS_CNT_W, 8: width of the lock-loss event counter.

Ports:
- clk  input  1  PLL output clock; single clock for the whole block.
- rst_n  input  1  synchronous, active-low reset.
- pll_lock  input  1  lock indication from the PLL; asynchronous to clk.
- sys_rst_n  output  1  registered system reset for downstream logic, active-low.
- tick  output  1  registered one-cycle strobe every TICK_DIV cycles while running.
- heartbeat  output  1  registered level, toggled every HB_TICKS ticks.
- state  output  2  current FSM state: 0=WAIT_LOCK, 1=STABILIZE, 2=RUN, 3=LOST.
- loss_count  output  LOSS_CNT_W  saturating count of lock losses from RUN.

Behaviour:
- Reset (rst_n sampled low at posedge clk):
  - state=WAIT_LOCK, sys_rst_n=0, tick=0, heartbeat=0, loss_count=0.
  - Both synchroniser flops, stab_cnt, tick_cnt and hb_cnt are cleared.
  - rst_n has priority over every other event.
- Synchroniser:
  - pll_lock passes through 2 flops; the internal lock_s is the second flop.
  - Latency from pll_lock to lock_s is 2 edges.
  - The FSM uses only lock_s.
- WAIT_LOCK:
  - sys_rst_n=0, stab_cnt=0.
  - If lock_s=1, go to STABILIZE with stab_cnt=0.
- STABILIZE:
  - sys_rst_n=0.
  - If lock_s=0, go to WAIT_LOCK. This is a glitch: loss_count does not change.
  - Else if stab_cnt==STABLE_CYCLES-1, go to RUN. sys_rst_n<=1, tick_cnt<=0 and hb_cnt<=0 on the same edge.
  - Else stab_cnt<=stab_cnt+1.
- Release timing: with pll_lock high before edge 0 and rst_n high from edge 0, sys_rst_n is first high after edge STABLE_CYCLES+2.
- RUN:
  - sys_rst_n=1.
  - tick_cnt counts 0..TICK_DIV-1. On the edge where tick_cnt==TICK_DIV-1: tick_cnt<=0 and tick<=1. Otherwise tick<=0.
  - On the edge where tick is set, if hb_cnt==HB_TICKS-1 then hb_cnt<=0 and heartbeat toggles; otherwise hb_cnt increments.
  - If lock_s=0, go to LOST. On the same edge: sys_rst_n<=0, tick<=0, tick_cnt<=0, and loss_count<=loss_count+1, saturating at all-ones.
  - Lock loss takes priority over tick generation on that edge.
- LOST:
  - sys_rst_n=0, tick=0.
  - Unconditionally go to WAIT_LOCK on the next edge.
  - Stabilisation always restarts from zero, even if lock has already returned.
- heartbeat holds its value outside RUN; only rst_n clears it.
- All counters are sized to hold their parameter maximum. There is no wrap-around other than the defined reloads.
- Assertion latency: pll_lock falling to sys_rst_n low is 3 edges (2 synchroniser edges + 1 registered).

Test Plan:
Bench parameters: STABLE_CYCLES=16, TICK_DIV=10, HB_TICKS=3, LOSS_CNT_W=2.
1. Reset: rst_n low for 3 edges with pll_lock=1 -> sys_rst_n=0, tick=0, heartbeat=0, state=0 and loss_count=0 after the first low edge and throughout.
2. Clean lock: pll_lock high before edge 0, rst_n high from edge 0 -> state=1 after edge 2; state=2 and sys_rst_n=1 first after edge 18, not before.
3. Glitch during STABILIZE: pll_lock low for 1 cycle around edge 10 -> state returns to 0, loss_count stays 0, sys_rst_n release delayed to 16 locked cycles after relock.
4. Tick/heartbeat in RUN: first tick high after the 10th edge in RUN, then every 10 cycles, each exactly 1 cycle wide; heartbeat toggles 0->1 on the 3rd tick and 1->0 on the 6th.
5. Loss in RUN: pll_lock falls -> sys_rst_n=0 after 3 edges, state=3 for one cycle then 0, loss_count=1. Repeat 5 loss/relock cycles -> loss_count saturates at 3.
6. rst_n low for 1 edge mid-RUN with loss_count=2 -> state=0, sys_rst_n=0, heartbeat=0, loss_count=0 on that edge; a full re-stabilisation is required before release.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Holds system reset until the synchronised PLL lock has been stable long enough, then runs a
// tick/heartbeat generator; re-asserts reset and counts the event when lock is lost.
module pll_reset_sequencer #(
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned TICK_DIV      = 12000,
   parameter int unsigned HB_TICKS      = 500,
   parameter int unsigned LOSS_CNT_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_lock,
   output logic                  sys_rst_n,
   output logic                  tick,
   output logic                  heartbeat,
   output logic [1:0]            state,
   output logic [LOSS_CNT_W-1:0] loss_count
);

   localparam int unsigned StabW = $clog2(STABLE_CYCLES);
   localparam int unsigned TickW = $clog2(TICK_DIV);
   localparam int unsigned HbW   = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;

   localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);
   localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
   localparam logic [HbW-1:0]   HbLast   = HbW'(HB_TICKS - 1);

   typedef enum logic [1:0] {
      StWaitLock  = 2'd0,
      StStabilize = 2'd1,
      StRun       = 2'd2,
      StLost      = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic                  sync1_q, sync2_q;
   logic [StabW-1:0]      stab_cnt_q, stab_cnt_d;
   logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [HbW-1:0]        hb_cnt_q, hb_cnt_d;
   logic                  sys_rst_n_q, sys_rst_n_d;
   logic                  tick_q, tick_d;
   logic                  heartbeat_q, heartbeat_d;
   logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;
   logic                  lock_s;

   assign lock_s = sync2_q;

   always_comb begin
      state_d      = state_q;
      stab_cnt_d   = stab_cnt_q;
      tick_cnt_d   = tick_cnt_q;
      hb_cnt_d     = hb_cnt_q;
      sys_rst_n_d  = 1'b0;
      tick_d       = 1'b0;
      heartbeat_d  = heartbeat_q;
      loss_count_d = loss_count_q;

      unique case (state_q)
         StWaitLock: begin
            stab_cnt_d = '0;
            if (lock_s) begin
               state_d = StStabilize;
            end
         end
         StStabilize: begin
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (stab_cnt_q == StabLast) begin
               state_d     = StRun;
               sys_rst_n_d = 1'b1;
               tick_cnt_d  = '0;
               hb_cnt_d    = '0;
            end else begin
               stab_cnt_d = stab_cnt_q + StabW'(1);
            end
         end
         StRun: begin
            // Lock loss wins over a tick that would fall on the same edge.
            if (!lock_s) begin
               state_d    = StLost;
               tick_cnt_d = '0;
               if (loss_count_q != {LOSS_CNT_W{1'b1}}) begin
                  loss_count_d = loss_count_q + LOSS_CNT_W'(1);
               end
            end else begin
               sys_rst_n_d = 1'b1;
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d = '0;
                  tick_d     = 1'b1;
                  if (hb_cnt_q == HbLast) begin
                     hb_cnt_d    = '0;
                     heartbeat_d = ~heartbeat_q;
                  end else begin
                     hb_cnt_d = hb_cnt_q + HbW'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TickW'(1);
               end
            end
         end
         StLost: begin
            state_d = StWaitLock;
         end
         default: begin
            state_d = StWaitLock;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StWaitLock;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stab_cnt_q   <= '0;
         tick_cnt_q   <= '0;
         hb_cnt_q     <= '0;
         sys_rst_n_q  <= 1'b0;
         tick_q       <= 1'b0;
         heartbeat_q  <= 1'b0;
         loss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= pll_lock;
         sync2_q      <= sync1_q;
         stab_cnt_q   <= stab_cnt_d;
         tick_cnt_q   <= tick_cnt_d;
         hb_cnt_q     <= hb_cnt_d;
         sys_rst_n_q  <= sys_rst_n_d;
         tick_q       <= tick_d;
         heartbeat_q  <= heartbeat_d;
         loss_count_q <= loss_count_d;
      end
   end

   assign sys_rst_n  = sys_rst_n_q;
   assign tick       = tick_q;
   assign heartbeat  = heartbeat_q;
   assign state      = state_q;
   assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock traffic, checked against a
// lock-streak reference model.
module tb_pll_reset_sequencer;

   localparam int unsigned STABLE_CYCLES = 16;
   localparam int unsigned TICK_DIV      = 10;
   localparam int unsigned HB_TICKS      = 3;
   localparam int unsigned LOSS_CNT_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  pll_lock;
   logic                  sys_rst_n;
   logic                  tick;
   logic                  heartbeat;
   logic [1:0]            state;
   logic [LOSS_CNT_W-1:0] loss_count;

   int checks   = 0;
   int failures = 0;

   // Reference model: outputs follow from how many consecutive edges lock_s has been seen high.
   logic                  m_s1, m_s2;
   int                    streak;
   bit                    cool;
   logic [1:0]            m_state;
   logic                  m_srst, m_tick, m_hb;
   logic [LOSS_CNT_W-1:0] m_loss;

   pll_reset_sequencer #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .TICK_DIV     (TICK_DIV),
      .HB_TICKS     (HB_TICKS),
      .LOSS_CNT_W   (LOSS_CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_lock  (pll_lock),
      .sys_rst_n (sys_rst_n),
      .tick      (tick),
      .heartbeat (heartbeat),
      .state     (state),
      .loss_count(loss_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      logic ls;
      int   run_edges;
      @(posedge clk);
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; streak = 0; cool = 0;
         m_state = 0; m_srst = 0; m_tick = 0; m_hb = 0; m_loss = 0;
      end else begin
         ls   = m_s2;
         m_s2 = m_s1;
         m_s1 = pll_lock;
         m_tick = 0;
         if (cool) begin
            cool = 0; streak = 0; m_state = 0;
         end else if (ls) begin
            streak++;
            if (streak <= STABLE_CYCLES) begin
               m_state = 1;
            end else begin
               m_state   = 2;
               run_edges = streak - STABLE_CYCLES - 1;
               if (run_edges > 0 && run_edges % TICK_DIV == 0) begin
                  m_tick = 1;
                  if ((run_edges / TICK_DIV) % HB_TICKS == 0) m_hb = ~m_hb;
               end
            end
         end else begin
            if (streak > STABLE_CYCLES) begin
               m_state = 3;
               cool    = 1;
               if (m_loss != {LOSS_CNT_W{1'b1}}) m_loss = m_loss + 1'b1;
            end else begin
               m_state = 0;
            end
            streak = 0;
         end
         m_srst = (m_state == 2);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 0;
      pll_lock = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({state, sys_rst_n, tick, heartbeat, loss_count} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state edge=%0d got st=%0d srst=%b tick=%b hb=%b loss=%0d want all zero",
                     i, state, sys_rst_n, tick, heartbeat, loss_count);
         end
      end
   endtask

   // Releases reset with pll_lock already high; checks STABILIZE entry and release edge.
   task automatic test_clean_lock();
      rst_n = 1;
      for (int e = 0; e <= int'(STABLE_CYCLES) + 2; e++) begin
         logic [1:0] want_st;
         step();
         want_st = (e < 2) ? 2'd0 : (e < int'(STABLE_CYCLES) + 2) ? 2'd1 : 2'd2;
         checks++;
         if (state !== want_st || sys_rst_n !== (want_st == 2'd2)) begin
            failures++;
            $display("FAIL clean_lock edge=%0d got st=%0d srst=%b want st=%0d", e, state, sys_rst_n,
                     want_st);
         end
      end
   endtask

   task automatic test_tick_hb();
      for (int k = 1; k <= 70; k++) begin
         step();
         checks++;
         if (tick !== (k % TICK_DIV == 0) || heartbeat !== ((k / (TICK_DIV * HB_TICKS)) % 2 == 1)) begin
            failures++;
            $display("FAIL tick_hb run_edge=%0d got tick=%b hb=%b want tick=%b hb=%b", k, tick,
                     heartbeat, (k % TICK_DIV == 0), ((k / (TICK_DIV * HB_TICKS)) % 2 == 1));
         end
      end
   endtask

   task automatic relock_to_run(input string name);
      pll_lock = 1;
      for (int i = 0; i < 40 && sys_rst_n !== 1'b1; i++) begin
         step();
         checks++;
         if ({state, sys_rst_n, tick, heartbeat, loss_count} !== {m_state, m_srst, m_tick, m_hb, m_loss})
         begin
            failures++;
            $display("FAIL %s got st=%0d srst=%b loss=%0d want st=%0d srst=%b loss=%0d", name, state,
                     sys_rst_n, loss_count, m_state, m_srst, m_loss);
         end
      end
      checks++;
      if (sys_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL %s_timeout got srst=%b want 1", name, sys_rst_n);
      end
   endtask

   // Drops lock from RUN n times; each drop must assert reset 3 edges later through LOST.
   task automatic test_loss(input int n);
      for (int r = 1; r <= n; r++) begin
         logic [LOSS_CNT_W-1:0] want_loss;
         want_loss = (r > 3) ? 2'd3 : LOSS_CNT_W'(r);
         pll_lock  = 0;
         for (int e = 1; e <= 4; e++) begin
            logic [1:0] want_st;
            step();
            want_st = (e < 3) ? 2'd2 : (e == 3) ? 2'd3 : 2'd0;
            checks++;
            if (state !== want_st || sys_rst_n !== (e < 3)
                || (e >= 3 && loss_count !== want_loss)) begin
               failures++;
               $display("FAIL loss r=%0d edge=%0d got st=%0d srst=%b loss=%0d want st=%0d loss=%0d",
                        r, e, state, sys_rst_n, loss_count, want_st, want_loss);
            end
         end
         relock_to_run("loss_relock");
      end
   endtask

   task automatic test_mid_run_reset();
      rst_n = 0;
      step();
      rst_n = 1;
      relock_to_run("mrr_lock");
      test_loss(2);
      for (int i = 0; i < 35; i++) step();
      checks++;
      if (heartbeat !== 1'b1 || loss_count !== 2'd2) begin
         failures++;
         $display("FAIL mrr_setup got hb=%b loss=%0d want hb=1 loss=2", heartbeat, loss_count);
      end
      rst_n = 0;
      step();
      rst_n = 1;
      checks++;
      if ({state, sys_rst_n, heartbeat, loss_count} !== 5'b0) begin
         failures++;
         $display("FAIL mrr_reset got st=%0d srst=%b hb=%b loss=%0d want all zero", state,
                  sys_rst_n, heartbeat, loss_count);
      end
      for (int e = 0; e <= int'(STABLE_CYCLES) + 2; e++) begin
         step();
         checks++;
         if (sys_rst_n !== (e == int'(STABLE_CYCLES) + 2)) begin
            failures++;
            $display("FAIL mrr_restab edge=%0d got srst=%b want %b", e, sys_rst_n,
                     (e == int'(STABLE_CYCLES) + 2));
         end
      end
   endtask

   // One-cycle lock glitch while stabilising: back to WAIT_LOCK, no loss counted, full restart.
   task automatic test_glitch();
      rst_n = 0;
      step();
      rst_n = 1;
      for (int e = 0; e <= 30; e++) begin
         pll_lock = (e != 10);
         step();
         if (e == 12 || e == 28 || e == 29) begin
            logic [1:0] want_st;
            want_st = (e == 12) ? 2'd0 : (e == 28) ? 2'd1 : 2'd2;
            checks++;
            if (state !== want_st || sys_rst_n !== (e == 29) || loss_count !== 2'd0) begin
               failures++;
               $display("FAIL glitch edge=%0d got st=%0d srst=%b loss=%0d want st=%0d", e, state,
                        sys_rst_n, loss_count, want_st);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 60; seg++) begin
         int len;
         pll_lock = (seg % 2 == 0);
         len = pll_lock ? int'($urandom_range(5, 70)) : int'($urandom_range(1, 6));
         if ($urandom_range(0, 15) == 0) rst_n = 0;
         for (int i = 0; i < len; i++) begin
            step();
            rst_n = 1;
            checks++;
            if ({state, sys_rst_n, tick, heartbeat, loss_count}
                !== {m_state, m_srst, m_tick, m_hb, m_loss}) begin
               failures++;
               $display("FAIL random seg=%0d got st=%0d srst=%b tick=%b hb=%b loss=%0d want st=%0d srst=%b tick=%b hb=%b loss=%0d",
                        seg, state, sys_rst_n, tick, heartbeat, loss_count, m_state, m_srst,
                        m_tick, m_hb, m_loss);
            end
         end
      end
   endtask

   initial begin
      rst_n    = 0;
      pll_lock = 0;
      test_reset();
      test_clean_lock();
      test_tick_hb();
      test_loss(5);
      test_mid_run_reset();
      test_glitch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
